gradient_mag_angle_pipe: RTL and testbench
==========================================

GRADIENT_MAG_ANGLE_PIPE -- requirements
Module: gradient_mag_angle_pipe

Interface
REQ-001 SHALL have parameter BITS, default 9: width of signed two's-complement gradient inputs.
REQ-002 SHALL have parameter PRECISION, default 8: width of output magnitude; legal range 1..BITS-1.
REQ-003 SHALL have parameter MAG_MODE, default 0: 0 = (|x|+|y|)/2, 1 = max(|x|,|y|) + min(|x|,|y|)/2.
REQ-004 clk  in  1  single clock, all state rising-edge.
REQ-005 n_rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  input sample present.
REQ-007 in_ready  out  1  block accepts sample this cycle.
REQ-008 in_x  in  BITS  signed horizontal gradient.
REQ-009 in_y  in  BITS  signed vertical gradient.
REQ-010 in_last  in  1  end-of-row marker, passed through with sample.
REQ-011 threshold  in  PRECISION  edge threshold, quasi-static.
REQ-012 out_valid  out  1  output sample present.
REQ-013 out_ready  in  1  downstream accepts output.
REQ-014 out_mag  out  PRECISION  unsigned saturated magnitude.
REQ-015 out_dir  out  2  quantised direction code.
REQ-016 out_edge  out  1  out_mag >= threshold.
REQ-017 out_last  out  1  in_last of this sample.

Function
REQ-018 Transfer occurs on a valid&&ready cycle at either port; a sample SHALL be neither dropped nor duplicated, and order SHALL be preserved.
REQ-019 Three register stages: S1 absolute values + sign flags; S2 raw magnitude + direction; S3 saturation, threshold, outputs.
REQ-020 Latency SHALL be 3 cycles from input transfer to out_valid when out_ready stays high; throughput 1 sample/cycle.
REQ-021 stall = out_valid && !out_ready; in_ready SHALL equal !stall; while stalled all stages SHALL hold contents; bubbles are not squeezed.
REQ-022 Output signals SHALL remain stable while out_valid && !out_ready.
REQ-023 |v| SHALL be computed in BITS unsigned bits so -2^(BITS-1) yields 2^(BITS-1) exactly.
REQ-024 Raw magnitude per MAG_MODE in BITS+1 bits, then right-shifted by BITS-1-PRECISION; result > 2^PRECISION-1 SHALL saturate to 2^PRECISION-1.
REQ-025 Direction with ax=|x|, ay=|y|, comparisons in BITS+2 bits: 2*ay+(ay>>1) <= ax -> DIR_H (0); else ay <= 2*ax+(ax>>1) -> diagonal; else DIR_V (2).
REQ-026 Diagonal SHALL be DIR_D45 (1) when sign(x)==sign(y), DIR_D135 (3) otherwise; zero counts as non-negative.
REQ-027 out_edge SHALL compare saturated magnitude against threshold sampled when S2 advances into S3.
REQ-028 in_last SHALL travel with its sample through every stage unmodified.

Reset
REQ-029 n_rst low SHALL immediately clear all stage valid flags; out_valid, out_mag, out_dir, out_edge, out_last SHALL read 0.
REQ-030 Reset mid-stream SHALL discard all in-flight samples; first transfer after release SHALL emerge 3 cycles later.
REQ-031 in_ready SHALL be 1 during and after reset (pipeline empty).

Structure
REQ-032 Package gradient_pkg SHALL hold the direction enum (DIR_H, DIR_D45, DIR_V, DIR_D135) and MAG_MODE constants.
REQ-033 One sub-module gradient_abs (BITS-wide signed -> BITS-wide unsigned magnitude plus sign bit), instantiated twice in S1.
REQ-034 Stage registers SHALL live in the top module; no other sub-modules.

Verification (BITS=9, PRECISION=8, MAG_MODE=0, threshold=45)
REQ-035 x=100,y=0 -> mag 50, dir 0, edge 1, 3 cycles after transfer.
REQ-036 x=40,y=40 -> mag 40, dir 1, edge 0; x=-40,y=40 -> mag 40, dir 3; x=0,y=-100 -> mag 50, dir 2.
REQ-037 x=-256,y=-256 -> mag saturates to 255, dir 1, edge 1.
REQ-038 Stream 8 samples, out_ready low cycles 4-7 -> in_ready low same cycles, all 8 outputs in order, held stable while stalled, in_last only on sample 8.
REQ-039 n_rst pulsed low with 3 samples in flight -> out_valid 0 immediately, none emerge; next sample out after 3 cycles.
REQ-040 MAG_MODE=1, x=200,y=100 -> raw 250, mag 250, dir 1.

Source files
------------

// File: rtl/gradient_pkg.sv
// Shared types and constants for the gradient magnitude/angle pipeline.
package gradient_pkg;

    // Quantised gradient direction, four sectors of 45 degrees.
    typedef enum logic [1:0] {
        DIR_H    = 2'd0,
        DIR_D45  = 2'd1,
        DIR_V    = 2'd2,
        DIR_D135 = 2'd3
    } dir_e;

    // Magnitude approximation selectors.
    localparam int MAG_MODE_SUM_HALF     = 0;  // (|x|+|y|)/2
    localparam int MAG_MODE_MAX_MIN_HALF = 1;  // max + min/2

endpackage

// File: rtl/gradient_mag_angle_pipe_if.sv
// Streaming input/output bundle for the gradient magnitude/angle pipeline.
interface gradient_mag_angle_pipe_if #(
    parameter int BITS      = 9,
    parameter int PRECISION = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [BITS-1:0]      in_x;
    logic signed [BITS-1:0]      in_y;
    logic                        in_last;
    logic [PRECISION-1:0]        threshold;
    logic                        out_valid;
    logic                        out_ready;
    logic [PRECISION-1:0]        out_mag;
    logic [1:0]                  out_dir;
    logic                        out_edge;
    logic                        out_last;

    // Upstream/downstream environment side.
    modport master (
        output in_valid, in_x, in_y, in_last, threshold, out_ready,
        input  in_ready, out_valid, out_mag, out_dir, out_edge, out_last
    );

    // Pipeline side.
    modport slave (
        input  in_valid, in_x, in_y, in_last, threshold, out_ready,
        output in_ready, out_valid, out_mag, out_dir, out_edge, out_last
    );
endinterface

// File: rtl/gradient_abs.sv
// Signed to unsigned magnitude; the result keeps BITS bits so the most
// negative input maps to 2^(BITS-1) without overflow.
module gradient_abs #(
    parameter int BITS = 9
) (
    input  logic signed [BITS-1:0] v,
    output logic        [BITS-1:0] mag,
    output logic                   neg
);
    localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

    // Two's-complement negate when the sign bit is set; zero counts as non-negative.
    always_comb begin
        neg = v[BITS-1];
        if (v[BITS-1]) begin
            mag = ~v + ONE;
        end else begin
            mag = v;
        end
    end
endmodule

// File: rtl/gradient_mag_angle_pipe.sv
// Three-stage gradient magnitude and direction pipeline with a global
// stall: when the output is held, every stage holds.
module gradient_mag_angle_pipe
    import gradient_pkg::*;
#(
    parameter int BITS      = 9,
    parameter int PRECISION = 8,
    parameter int MAG_MODE  = 0
) (
    input  logic                      clk,
    input  logic                      n_rst,
    gradient_mag_angle_pipe_if.slave  bus
);
    localparam int              SHIFT   = BITS - 1 - PRECISION;
    localparam int              CW      = BITS + 2;
    localparam logic [BITS:0]   MAG_MAX = {{(BITS+1-PRECISION){1'b0}}, {PRECISION{1'b1}}};

    // Stage 1: absolute values and sign flags
    logic                 s1_valid_r;
    logic [BITS-1:0]      s1_ax_r;
    logic [BITS-1:0]      s1_ay_r;
    logic                 s1_neg_x_r;
    logic                 s1_neg_y_r;
    logic                 s1_last_r;
    // Stage 2: raw magnitude and direction
    logic                 s2_valid_r;
    logic [BITS:0]        s2_raw_r;
    dir_e                 s2_dir_r;
    logic                 s2_last_r;
    // Stage 3: saturated magnitude, edge flag, outputs
    logic                 s3_valid_r;
    logic [PRECISION-1:0] s3_mag_r;
    dir_e                 s3_dir_r;
    logic                 s3_edge_r;
    logic                 s3_last_r;

    logic                 stall_s;
    logic [BITS-1:0]      abs_x_s;
    logic [BITS-1:0]      abs_y_s;
    logic                 neg_x_s;
    logic                 neg_y_s;
    logic [BITS:0]        ax_w_s;
    logic [BITS:0]        ay_w_s;
    logic [BITS:0]        raw_s;
    logic [CW-1:0]        ax_ext_s;
    logic [CW-1:0]        ay_ext_s;
    logic [CW-1:0]        h_lim_s;
    logic [CW-1:0]        v_lim_s;
    dir_e                 dir_s;
    logic [BITS:0]        shifted_s;
    logic [PRECISION-1:0] sat_s;
    logic                 edge_s;

    assign stall_s = s3_valid_r & ~bus.out_ready;

    gradient_abs #(.BITS(BITS)) u_abs_x (.v(bus.in_x), .mag(abs_x_s), .neg(neg_x_s));
    gradient_abs #(.BITS(BITS)) u_abs_y (.v(bus.in_y), .mag(abs_y_s), .neg(neg_y_s));

    assign ax_w_s   = {1'b0, s1_ax_r};
    assign ay_w_s   = {1'b0, s1_ay_r};
    assign ax_ext_s = {2'b00, s1_ax_r};
    assign ay_ext_s = {2'b00, s1_ay_r};
    assign h_lim_s  = (ay_ext_s << 1'b1) + (ay_ext_s >> 1'b1);
    assign v_lim_s  = (ax_ext_s << 1'b1) + (ax_ext_s >> 1'b1);

    // Raw magnitude approximation selected by MAG_MODE.
    always_comb begin
        raw_s = {(BITS+1){1'b0}};
        if (MAG_MODE == MAG_MODE_MAX_MIN_HALF) begin
            if (ax_w_s >= ay_w_s) begin
                raw_s = ax_w_s + (ay_w_s >> 1'b1);
            end else begin
                raw_s = ay_w_s + (ax_w_s >> 1'b1);
            end
        end else begin
            raw_s = (ax_w_s + ay_w_s) >> 1'b1;
        end
    end

    // Sector decision using tan(22.5)/tan(67.5) ~ 2.5 slope bounds.
    always_comb begin
        dir_s = DIR_H;
        if (h_lim_s <= ax_ext_s) begin
            dir_s = DIR_H;
        end else if (ay_ext_s <= v_lim_s) begin
            if (s1_neg_x_r == s1_neg_y_r) begin
                dir_s = DIR_D45;
            end else begin
                dir_s = DIR_D135;
            end
        end else begin
            dir_s = DIR_V;
        end
    end

    // Scale to output precision, clamp, and compare against the live threshold.
    always_comb begin
        shifted_s = s2_raw_r >> SHIFT;
        if (shifted_s > MAG_MAX) begin
            sat_s = {PRECISION{1'b1}};
        end else begin
            sat_s = shifted_s[PRECISION-1:0];
        end
        edge_s = (sat_s >= bus.threshold);
    end

    // Stage 1 register: capture absolute values whenever the pipe advances.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid_r <= 1'b0;
            s1_ax_r    <= {BITS{1'b0}};
            s1_ay_r    <= {BITS{1'b0}};
            s1_neg_x_r <= 1'b0;
            s1_neg_y_r <= 1'b0;
            s1_last_r  <= 1'b0;
        end else if (!stall_s) begin
            s1_valid_r <= bus.in_valid;
            s1_ax_r    <= abs_x_s;
            s1_ay_r    <= abs_y_s;
            s1_neg_x_r <= neg_x_s;
            s1_neg_y_r <= neg_y_s;
            s1_last_r  <= bus.in_last;
        end
    end

    // Stage 2 register: raw magnitude and direction code.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s2_valid_r <= 1'b0;
            s2_raw_r   <= {(BITS+1){1'b0}};
            s2_dir_r   <= DIR_H;
            s2_last_r  <= 1'b0;
        end else if (!stall_s) begin
            s2_valid_r <= s1_valid_r;
            s2_raw_r   <= raw_s;
            s2_dir_r   <= dir_s;
            s2_last_r  <= s1_last_r;
        end
    end

    // Stage 3 register: final outputs, held while downstream stalls.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s3_valid_r <= 1'b0;
            s3_mag_r   <= {PRECISION{1'b0}};
            s3_dir_r   <= DIR_H;
            s3_edge_r  <= 1'b0;
            s3_last_r  <= 1'b0;
        end else if (!stall_s) begin
            s3_valid_r <= s2_valid_r;
            s3_mag_r   <= sat_s;
            s3_dir_r   <= s2_dir_r;
            s3_edge_r  <= edge_s;
            s3_last_r  <= s2_last_r;
        end
    end

    assign bus.in_ready  = ~stall_s;
    assign bus.out_valid = s3_valid_r;
    assign bus.out_mag   = s3_mag_r;
    assign bus.out_dir   = s3_dir_r;
    assign bus.out_edge  = s3_edge_r;
    assign bus.out_last  = s3_last_r;
endmodule

// File: tb/tb_gradient_mag_angle_pipe.sv
// Bench for gradient_mag_angle_pipe: directed vectors, stall stream,
// mid-stream reset and random traffic against an arithmetic model.
module tb_gradient_mag_angle_pipe;
    localparam int TB_BITS = 9;
    localparam int TB_PREC = 8;

    typedef struct { int mag; int dir; int edg; int last; } exp_t;
    typedef struct { int x; int y; int last; int mode; int mag; int dir; int edg; } vec_t;

    logic              clk;
    logic              n_rst;
    logic              in_valid;
    logic              in_last;
    logic signed [8:0] in_x;
    logic signed [8:0] in_y;
    logic [7:0]        thr;
    logic              out_ready;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out0  = 0;
    int   n_out1  = 0;
    exp_t q0[$];
    exp_t q1[$];
    vec_t tbl[7];

    gradient_mag_angle_pipe_if #(.BITS(TB_BITS), .PRECISION(TB_PREC)) if0 ();
    gradient_mag_angle_pipe_if #(.BITS(TB_BITS), .PRECISION(TB_PREC)) if1 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if0.in_x = in_x;          assign if1.in_x = in_x;
    assign if0.in_y = in_y;          assign if1.in_y = in_y;
    assign if0.in_last = in_last;    assign if1.in_last = in_last;
    assign if0.threshold = thr;      assign if1.threshold = thr;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

    gradient_mag_angle_pipe #(.BITS(TB_BITS), .PRECISION(TB_PREC), .MAG_MODE(0)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .bus(if0));
    gradient_mag_angle_pipe #(.BITS(TB_BITS), .PRECISION(TB_PREC), .MAG_MODE(1)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the stated rules.
    function automatic exp_t model(input int x, input int y, input int mode, input int t, input int last);
        exp_t e;
        int ax, ay, raw, m;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        if (mode == 0) raw = (ax + ay) / 2;
        else if (ax >= ay) raw = ax + ay / 2;
        else raw = ay + ax / 2;
        m = raw / (1 << (TB_BITS - 1 - TB_PREC));
        if (m > (1 << TB_PREC) - 1) m = (1 << TB_PREC) - 1;
        e.mag = m;
        e.edg = (m >= t) ? 1 : 0;
        if (2 * ay + ay / 2 <= ax) e.dir = 0;
        else if (ay <= 2 * ax + ax / 2) e.dir = ((x < 0) == (y < 0)) ? 1 : 3;
        else e.dir = 2;
        e.last = last;
        return e;
    endfunction

    task automatic sb_step(input int m, input logic ir, input logic ov, input logic [7:0] om,
                           input logic [1:0] od, input logic oe, input logic ol);
        exp_t e;
        int   sz;
        sz = (m == 0) ? q0.size() : q1.size();
        if (ov) begin
            if (sz == 0) begin
                chk($sformatf("sb%0d_unexpected_out", m), 1, 0);
            end else begin
                e = (m == 0) ? q0[0] : q1[0];
                chk($sformatf("sb%0d_mag", m), int'(om), e.mag);
                chk($sformatf("sb%0d_dir", m), int'(od), e.dir);
                chk($sformatf("sb%0d_edge", m), int'(oe), e.edg);
                chk($sformatf("sb%0d_last", m), int'(ol), e.last);
                if (out_ready) begin
                    if (m == 0) begin void'(q0.pop_front()); n_out0++; end
                    else begin void'(q1.pop_front()); n_out1++; end
                end
            end
        end
        if (in_valid && ir) begin
            e = model(int'(in_x), int'(in_y), m, int'(thr), int'(in_last));
            if (m == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    // Scoreboard: sample both ports mid-cycle; a reset discards in-flight expectations.
    always @(negedge clk) begin
        if (!n_rst) begin
            q0.delete();
            q1.delete();
        end else begin
            sb_step(0, if0.in_ready, if0.out_valid, if0.out_mag, if0.out_dir, if0.out_edge, if0.out_last);
            sb_step(1, if1.in_ready, if1.out_valid, if1.out_mag, if1.out_dir, if1.out_edge, if1.out_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single sample with exact latency check on the DUT selected by v.mode.
    task automatic apply_vec(input vec_t v, input string tag);
        logic ov;
        in_valid = 1'b1;
        in_x = v.x[8:0];
        in_y = v.y[8:0];
        in_last = v.last[0];
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, int'(if0.in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            ov = (v.mode == 0) ? if0.out_valid : if1.out_valid;
            chk($sformatf("%s_early_valid%0d", tag, k), int'(ov), 0);
            tick();
        end
        @(negedge clk);
        if (v.mode == 0) begin
            chk({tag, "_valid"}, int'(if0.out_valid), 1);
            chk({tag, "_mag"}, int'(if0.out_mag), v.mag);
            chk({tag, "_dir"}, int'(if0.out_dir), v.dir);
            chk({tag, "_edge"}, int'(if0.out_edge), v.edg);
            chk({tag, "_last"}, int'(if0.out_last), v.last);
        end else begin
            chk({tag, "_valid"}, int'(if1.out_valid), 1);
            chk({tag, "_mag"}, int'(if1.out_mag), v.mag);
            chk({tag, "_dir"}, int'(if1.out_dir), v.dir);
            chk({tag, "_edge"}, int'(if1.out_edge), v.edg);
            chk({tag, "_last"}, int'(if1.out_last), v.last);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   idx;
        int   base0;
        int   r;
        vec_t rv;

        tbl[0] = '{x: 100,  y: 0,    last: 0, mode: 0, mag: 50,  dir: 0, edg: 1};
        tbl[1] = '{x: 40,   y: 40,   last: 0, mode: 0, mag: 40,  dir: 1, edg: 0};
        tbl[2] = '{x: -40,  y: 40,   last: 0, mode: 0, mag: 40,  dir: 3, edg: 0};
        tbl[3] = '{x: 0,    y: -100, last: 1, mode: 0, mag: 50,  dir: 2, edg: 1};
        tbl[4] = '{x: -256, y: -256, last: 0, mode: 0, mag: 255, dir: 1, edg: 1};
        tbl[5] = '{x: 200,  y: 100,  last: 1, mode: 1, mag: 250, dir: 1, edg: 1};
        tbl[6] = '{x: 100,  y: 0,    last: 0, mode: 1, mag: 100, dir: 0, edg: 1};

        n_rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_x = 9'sd0;
        in_y = 9'sd0;
        thr = 8'd45;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", int'(if0.out_valid), 0);
        chk("rst_out_mag", int'(if0.out_mag), 0);
        chk("rst_in_ready", int'(if0.in_ready), 1);
        chk("rst_in_ready_m1", int'(if1.in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Directed vectors
        for (int i = 0; i < 7; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Stream of 8 with downstream stalled in cycles 4..7
        base0 = n_out0;
        idx = 0;
        for (int c = 1; c <= 60; c++) begin
            out_ready = !(c >= 4 && c <= 7);
            if (idx < 8) begin
                in_valid = 1'b1;
                rv.x = idx * 30 - 100;
                rv.y = 50 - idx * 17;
                in_x = rv.x[8:0];
                in_y = rv.y[8:0];
                in_last = (idx == 7);
            end else begin
                in_valid = 1'b0;
                in_last = 1'b0;
            end
            @(negedge clk);
            if (c <= 10) chk($sformatf("stall_in_ready_c%0d", c), int'(if0.in_ready), (c >= 4 && c <= 7) ? 0 : 1);
            if (in_valid && if0.in_ready) idx++;
            tick();
            if (idx == 8 && q0.size() == 0 && q1.size() == 0) break;
        end
        in_valid = 1'b0;
        chk("stream_count", n_out0 - base0, 8);

        // Reset with three samples in flight
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_x = 9'sd120;
            in_y = -9'sd7;
            in_last = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("midrst_out_valid", int'(if0.out_valid), 0);
        chk("midrst_out_valid_m1", int'(if1.out_valid), 0);
        chk("midrst_mag", int'(if0.out_mag), 0);
        chk("midrst_dir", int'(if0.out_dir), 0);
        chk("midrst_edge", int'(if0.out_edge), 0);
        chk("midrst_in_ready", int'(if0.in_ready), 1);
        tick();
        n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("postrst_quiet%0d", k), int'(if0.out_valid), 0);
            tick();
        end
        apply_vec(tbl[0], "postrst");

        // Random traffic against the model
        thr = 8'($urandom_range(0, 255));
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            in_x = (r == 0) ? -9'sd256 : (r == 1) ? 9'sd255 : 9'($urandom_range(0, 511));
            r = $urandom_range(0, 9);
            in_y = (r == 0) ? -9'sd256 : (r == 1) ? -9'sd1 : 9'($urandom_range(0, 511));
            in_last = ($urandom_range(0, 7) == 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            tick();
        end
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
